// File: rtl/dmp_domain_ctrl.sv
// Domain-switch controller: owns the current protection domain seen by the
// decoders and sequences chdom/retdom at commit. A switch waits for the LSU to
// drain, then updates the domain and a bounded return-domain stack in a single
// cycle. Stack overflow on chdom and underflow on retdom raise a fault pulse
// (cause is always illegal-instruction).
module dmp_domain_ctrl #(
    parameter int unsigned     StackDepth = 4,
    parameter int unsigned     DomW       = 2,
    parameter logic [DomW-1:0] ResetDom   = '0,
    localparam int unsigned    DepthW     = $clog2(StackDepth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              commit_valid_i,
    input  logic              commit_chg_dom_i,
    input  logic              commit_ret_i,
    input  logic [DomW-1:0]   commit_target_dom_i,
    input  logic              lsu_empty_i,
    input  logic              flush_i,
    output logic [DomW-1:0]   curdom_o,
    output logic              halt_issue_o,
    output logic              switch_done_o,
    output logic              ex_valid_o,
    output logic [DepthW-1:0] depth_o
);

    localparam int unsigned IdxW = (StackDepth > 1) ? $clog2(StackDepth) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] SWITCH = 2'd2;
    localparam logic [1:0] FAULT  = 2'd3;

    localparam logic [DepthW-1:0] DepthFull = DepthW'(StackDepth);
    localparam logic [DepthW-1:0] DepthOne  = DepthW'(1);

    logic [1:0]        state_q, state_d;
    logic              req;
    logic              ret_q;
    logic [DomW-1:0]   tgt_q;
    logic [DomW-1:0]   curdom_q;
    logic [DepthW-1:0] depth_q;
    logic [DomW-1:0]   stack_q [StackDepth];
    logic [IdxW-1:0]   push_idx, top_idx;

    assign req      = commit_valid_i && commit_chg_dom_i;
    assign push_idx = IdxW'(depth_q);
    assign top_idx  = IdxW'(depth_q - DepthOne);

    // Next-state logic; limits are checked once at acceptance because the
    // stack only moves in SWITCH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!flush_i && req) begin
                    if (commit_ret_i ? (depth_q == '0) : (depth_q == DepthFull))
                        state_d = FAULT;
                    else
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (flush_i)          state_d = IDLE;
                else if (lsu_empty_i) state_d = SWITCH;
            end
            SWITCH:  state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Capture the request's kind and target when it is accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ret_q <= 1'b0;
            tgt_q <= '0;
        end else if (state_q == IDLE && req) begin
            ret_q <= commit_ret_i;
            tgt_q <= commit_target_dom_i;
        end
    end

    // Current domain and stack depth change only at the end of SWITCH.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            curdom_q <= ResetDom;
            depth_q  <= '0;
        end else if (state_q == SWITCH) begin
            if (ret_q) begin
                curdom_q <= stack_q[top_idx];
                depth_q  <= depth_q - DepthOne;
            end else begin
                curdom_q <= tgt_q;
                depth_q  <= depth_q + DepthOne;
            end
        end
    end

    // Stack storage; contents beyond depth are don't-care so no reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && state_q == SWITCH && !ret_q)
            stack_q[push_idx] <= curdom_q;
    end

    assign curdom_o      = curdom_q;
    assign depth_o       = depth_q;
    assign halt_issue_o  = (state_q == DRAIN) || (state_q == SWITCH);
    assign switch_done_o = (state_q == SWITCH);
    assign ex_valid_o    = (state_q == FAULT);

endmodule

// File: tb/tb_dmp_domain_ctrl.sv
// Bench for dmp_domain_ctrl: directed scenarios followed by random
// chdom/retdom traffic, checked against a queue-based domain-stack model.
module tb_dmp_domain_ctrl;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_i, commit_valid_i, commit_chg_dom_i, commit_ret_i;
    logic [1:0] commit_target_dom_i;
    logic       lsu_empty_i, flush_i;
    logic [1:0] curdom_o;
    logic       halt_issue_o, switch_done_o, ex_valid_o;
    logic [2:0] depth_o;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: the return stack as a queue, plus the current domain.
    logic [1:0] m_stk[$];
    logic [1:0] m_cur;

    dmp_domain_ctrl #(.StackDepth(DEPTH), .DomW(2), .ResetDom(2'd0)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .commit_valid_i(commit_valid_i), .commit_chg_dom_i(commit_chg_dom_i),
        .commit_ret_i(commit_ret_i), .commit_target_dom_i(commit_target_dom_i),
        .lsu_empty_i(lsu_empty_i), .flush_i(flush_i),
        .curdom_o(curdom_o), .halt_issue_o(halt_issue_o),
        .switch_done_o(switch_done_o), .ex_valid_o(ex_valid_o), .depth_o(depth_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_arch(input string tag);
        chk({tag, "_cur"},   curdom_o, m_cur);
        chk({tag, "_depth"}, depth_o, m_stk.size());
    endtask

    task automatic chk_pulses(input string tag, input bit h, input bit d, input bit e);
        chk({tag, "_halt"}, halt_issue_o, h);
        chk({tag, "_done"}, switch_done_o, d);
        chk({tag, "_ex"},   ex_valid_o, e);
    endtask

    task automatic drop_req();
        commit_valid_i = 1'b0; commit_chg_dom_i = 1'b0; flush_i = 1'b0; lsu_empty_i = 1'b1;
    endtask

    // Called at posedge+1; leaves at posedge+1.
    task automatic do_reset();
        rst_i = 1'b1; drop_req();
        @(posedge clk); #1;
        rst_i = 1'b0;
        m_stk.delete(); m_cur = 2'd0;
        @(negedge clk);
        chk_pulses("rst", 0, 0, 0);
        chk_arch("rst");
        @(posedge clk); #1;
    endtask

    // One switch request starting in IDLE at cycle t. stalls = DRAIN cycles with
    // lsu_empty low; flush_at = DRAIN cycle index that flushes (-1 = none);
    // rst_sw = assert reset during the SWITCH cycle.
    task automatic do_req(input bit ret, input logic [1:0] tgt, input int stalls,
                          input int flush_at, input bit rst_sw);
        bit fault;
        fault = ret ? (m_stk.size() == 0) : (m_stk.size() == DEPTH);
        commit_valid_i = 1'b1; commit_chg_dom_i = 1'b1;
        commit_ret_i = ret; commit_target_dom_i = tgt;
        lsu_empty_i = 1'b1; flush_i = 1'b0;
        @(negedge clk);
        chk_pulses("t0", 0, 0, 0);
        @(posedge clk); #1;
        if (fault) begin
            @(negedge clk);
            chk_pulses("fault", 0, 0, 1);
            chk_arch("fault");
            @(posedge clk); #1;
            drop_req();
            @(negedge clk);
            chk_pulses("fault_after", 0, 0, 0);
            chk_arch("fault_after");
            @(posedge clk); #1;
            return;
        end
        for (int k = 0; k <= stalls; k++) begin
            lsu_empty_i = (k >= stalls);
            flush_i     = (k == flush_at);
            @(negedge clk);
            chk_pulses("drain", 1, 0, 0);
            @(posedge clk); #1;
            if (k == flush_at) begin
                drop_req();
                @(negedge clk);
                chk_pulses("flushed", 0, 0, 0);
                chk_arch("flushed");
                @(posedge clk); #1;
                return;
            end
        end
        flush_i = 1'b1;    // must be ignored during SWITCH
        if (rst_sw) rst_i = 1'b1;
        @(negedge clk);
        chk_pulses("switch", 1, 1, 0);
        @(posedge clk); #1;
        drop_req();
        if (rst_sw) begin
            rst_i = 1'b0;
            m_stk.delete(); m_cur = 2'd0;
        end else if (ret) begin
            m_cur = m_stk.pop_back();
        end else begin
            m_stk.push_back(m_cur);
            m_cur = tgt;
        end
        @(negedge clk);
        chk_pulses("post", 0, 0, 0);
        chk_arch("post");
        @(posedge clk); #1;
    endtask

    initial begin
        rst_i = 1'b1; commit_ret_i = 1'b0; commit_target_dom_i = 2'd0;
        drop_req();
        m_cur = 2'd0;
        @(posedge clk); #1;
        do_reset();

        // Basic chdom then round trip back.
        do_req(0, 2'd1, 0, -1, 0);
        do_req(1, 2'd0, 0, -1, 0);
        // Drain stall of 5 cycles.
        do_req(0, 2'd1, 5, -1, 0);
        do_reset();
        // Flush in DRAIN at t+2.
        do_req(0, 2'd2, 3, 1, 0);
        // Flush in IDLE wins over the request.
        commit_valid_i = 1'b1; commit_chg_dom_i = 1'b1; commit_ret_i = 1'b0;
        commit_target_dom_i = 2'd3; flush_i = 1'b1;
        @(posedge clk); #1;
        drop_req();
        @(negedge clk);
        chk_pulses("idle_flush", 0, 0, 0);
        chk_arch("idle_flush");
        @(posedge clk); #1;
        // Fill the stack (same-domain chdom included), then overflow.
        do_req(0, 2'd0, 0, -1, 0);
        for (int i = 1; i < DEPTH; i++) do_req(0, 2'(i), 0, -1, 0);
        do_req(0, 2'd2, 0, -1, 0);
        // Underflow after reset.
        do_reset();
        do_req(1, 2'd0, 0, -1, 0);
        // Reset during SWITCH.
        do_req(0, 2'd1, 0, -1, 0);
        do_req(0, 2'd2, 0, -1, 1);

        // Random traffic.
        for (int n = 0; n < 150; n++) begin
            bit         r;
            logic [1:0] tg;
            int         st, fa;
            r  = ($urandom_range(0, 99) < 45);
            tg = 2'($urandom_range(0, 3));
            st = $urandom_range(0, 3);
            fa = ($urandom_range(0, 9) < 2) ? $urandom_range(0, st) : -1;
            do_req(r, tg, st, fa, ($urandom_range(0, 49) == 0));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk_pulses("gap", 0, 0, 0);
                @(posedge clk); #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmp_domain_ctrl.md
# dmp_domain_ctrl

Domain-switch controller for the JIT domain-protection extension. It owns the architectural current domain (`curdom`) that the decoder checks against, and it sequences `chdom`/`retdom` at commit. Each switch drains outstanding memory operations, updates the domain, and keeps a bounded return-domain stack. Overflow and underflow of that stack raise an illegal-instruction fault. The block sits beside the commit stage and drives `curdom_i` of every decoder instance.

## Interface
Parameters:
- `StackDepth`, 4: number of return-domain entries (≥1).
- `ResetDom`, `riscv::DOM0`: value of `curdom_o` after reset.

Ports:
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset. Synchronous, active-high.
- `commit_valid_i`, in, 1: the commit-stage head instruction is valid.
- `commit_chg_dom_i`, in, 1: the head instruction has `chg_dom` set.
- `commit_ret_i`, in, 1: 1 = `retdom`, 0 = `chdom`. Sampled with the request.
- `commit_target_dom_i`, in, `riscv::dmp_domain_t`: target domain (`data_dom` of the head instruction). Used only by `chdom`.
- `lsu_empty_i`, in, 1: no loads or stores are in flight.
- `flush_i`, in, 1: pipeline flush.
- `curdom_o`, out, `riscv::dmp_domain_t`: current domain, fed to the decoders.
- `halt_issue_o`, out, 1: stall issue while a switch is pending.
- `switch_done_o`, out, 1: one-cycle pulse; commit may retire the switch instruction.
- `ex_valid_o`, out, 1: one-cycle fault pulse. The cause is always `riscv::ILLEGAL_INSTR`.
- `depth_o`, out, `$clog2(StackDepth+1)`: number of occupied stack entries.

## Operation
- Request = `commit_valid_i && commit_chg_dom_i`. The commit stage holds the request stable until it sees `switch_done_o` or `ex_valid_o`.
- FSM states: IDLE, DRAIN, SWITCH, FAULT.
- IDLE:
  - If `flush_i` is high, stay in IDLE and ignore any request (flush wins).
  - A `chdom` request with `depth == StackDepth` goes to FAULT.
  - A `retdom` request with `depth == 0` goes to FAULT.
  - Any other request goes to DRAIN.
- DRAIN:
  - `halt_issue_o = 1`.
  - `flush_i` returns to IDLE with no state change.
  - Otherwise, if `lsu_empty_i` is high, go to SWITCH; if not, stay in DRAIN.
- SWITCH (exactly 1 cycle):
  - `halt_issue_o = 1`, `switch_done_o = 1`.
  - `chdom`: push `curdom`, then set `curdom := commit_target_dom_i`.
  - `retdom`: set `curdom := top of stack`, then pop.
  - Return to IDLE.
  - `flush_i` during SWITCH is ignored; the switch has already committed.
- FAULT (exactly 1 cycle):
  - `ex_valid_o = 1`.
  - `curdom` and the stack are unchanged.
  - Return to IDLE.
- The stack is LIFO, so index `depth-1` is the top.
- A `chdom` whose target equals the current domain is legal and still pushes.
- `depth_o` never exceeds `StackDepth` and never underflows.
- Domain-legality checking is the decoder's job, not this block's; the controller trusts committed instructions.

## Timing
- Reset (synchronous, `rst_i` high at a rising edge):
  - FSM returns to IDLE, `depth = 0`, `curdom_o = ResetDom`.
  - `halt_issue_o`, `switch_done_o` and `ex_valid_o` are 0.
  - Reset during DRAIN or SWITCH aborts the switch with no partial update.
- Minimum switch latency, with the request first seen in cycle t and `lsu_empty_i = 1`:
  - t: IDLE.
  - t+1: DRAIN.
  - t+2: SWITCH, `switch_done_o = 1`.
  - t+3: the new `curdom_o` and `depth_o` are visible.
- Each cycle with `lsu_empty_i = 0` in DRAIN adds one cycle.
- `halt_issue_o` is high from t+1 through the SWITCH cycle inclusive. It is registered, so the decoder never sees a mid-switch domain.
- Fault latency: request at t in IDLE, `ex_valid_o` high at t+1, IDLE at t+2.
- The request at t+3 is the next instruction. Back-to-back switches are accepted every 3 cycles at best.
- All outputs are registered or decoded from FSM state only. There is no combinational path from inputs to outputs.

## Test plan
- Basic `chdom`:
  - Stimulus: reset; `chdom` target DOM1 with `lsu_empty_i = 1`.
  - Response: `switch_done_o` at t+2; `curdom_o = DOM1` and `depth_o = 1` at t+3; `halt_issue_o` high at t+1 and t+2 only.
- Round trip:
  - Stimulus: the basic `chdom` sequence, then `retdom`.
  - Response: `curdom_o = DOM0` and `depth_o = 0`; no `ex_valid_o`.
- Drain stall:
  - Stimulus: `chdom` DOM1 with `lsu_empty_i = 0` for 5 cycles.
  - Response: DRAIN is held 5 extra cycles; `switch_done_o` at t+7; `curdom_o = DOM1` at t+8.
- Flush in DRAIN:
  - Stimulus: `chdom` DOM2 with `lsu_empty_i = 0`; `flush_i` pulsed at t+2.
  - Response: IDLE at t+3; `curdom_o = DOM0`, `depth_o = 0`; no done pulse and no fault.
- Stack limits (`StackDepth = 4`):
  - Stimulus: 4 `chdom` requests, then a 5th.
  - Response: the 5th gives `ex_valid_o` one cycle after its request; `depth_o` stays 4; `curdom_o` is unchanged.
  - Stimulus: after reset, a `retdom` with empty stack.
  - Response: `ex_valid_o` at t+1; `curdom_o = DOM0`.
- Reset mid-switch:
  - Stimulus: assert `rst_i` during SWITCH of a `chdom` DOM1.
  - Response: next cycle `curdom_o = DOM0`, `depth_o = 0`, all pulses 0.
